// File: rtl/shared_unit_arbiter_pkg.sv
// Shared types and default sizing for the shared-unit arbiter.
package shared_unit_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_DW      = 4;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/shared_unit_arbiter_rr_pick.sv
// Combinational round-robin search: lowest requester at or above i_ptr,
// wrapping to the lowest requester overall when none is at or above it.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic          o_any
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] w_below;
    logic [N-1:0] w_masked;
    logic [N-1:0] w_sel;

    assign w_below  = (ONE << i_ptr) - ONE;
    assign w_masked = i_req & ~w_below;
    assign w_sel    = (|w_masked) ? w_masked : i_req;
    // Two's-complement trick isolates the lowest set bit.
    assign o_gnt    = w_sel & (~w_sel + ONE);
    assign o_any    = |i_req;

endmodule

// File: rtl/shared_unit_arbiter.sv
// Round-robin arbiter multiplexing N_REQ requesters onto one shared unit.
// Optional WAIT watchdog enabled by defining ARB_TIMEOUT_EN.
module shared_unit_arbiter
    import shared_unit_arbiter_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_data,
    output logic                rsp_err,
    output logic [DW-1:0]       u_in,
    output logic                u_start,
    input  logic                u_done,
    input  logic [DW-1:0]       u_result,
    output logic                busy,
    inout  wire                 VDD,
    inout  wire                 VSS
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       r_state, w_state_next;
    logic [PW-1:0]    r_ptr, w_ptr_next;
    logic [N_REQ-1:0] r_owner, w_owner_next;
    logic [N_REQ-1:0] r_gnt, w_gnt_next;
    logic [N_REQ-1:0] r_rsp_valid, w_rsp_valid_next;
    logic [DW-1:0]    r_rsp_data, w_rsp_data_next;
    logic [DW-1:0]    r_u_in, w_u_in_next;
    logic             r_u_start, w_u_start_next;
    logic             r_busy, w_busy_next;

    logic [N_REQ-1:0] w_pick;
    logic             w_any;
    logic [DW-1:0]    w_operand;
    logic [PW-1:0]    w_owner_idx;
    logic             w_unused_pwr;

    assign w_unused_pwr = VDD ^ VSS;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_rsp_err, w_rsp_err_next;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    rr_pick #(.N(N_REQ), .PW(PW)) u_rr_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick),
        .o_any (w_any)
    );

    always_comb begin
        w_operand   = '0;
        w_owner_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i])  w_operand   = w_operand | req_data[i*DW +: DW];
            if (r_owner[i]) w_owner_idx = w_owner_idx | PW'(i);
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_ptr_next       = r_ptr;
        w_owner_next     = r_owner;
        w_gnt_next       = '0;
        w_rsp_valid_next = '0;
        w_rsp_data_next  = r_rsp_data;
        w_u_in_next      = r_u_in;
        w_u_start_next   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_cnt_next       = r_cnt;
        w_rsp_err_next   = r_rsp_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_gnt_next   = w_pick;
                    w_owner_next = w_pick;
                    w_u_in_next  = w_operand;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_u_start_next = 1'b1;
                w_state_next   = ST_WAIT;
`ifdef ARB_TIMEOUT_EN
                w_cnt_next     = '0;
`endif
            end
            ST_WAIT: begin
                // u_done coinciding with the start pulse belongs to the issue cycle.
                if (u_done && !r_u_start) begin
                    w_rsp_data_next  = u_result;
                    w_rsp_valid_next = r_owner;
                    w_state_next     = ST_RESP;
`ifdef ARB_TIMEOUT_EN
                    w_rsp_err_next   = 1'b0;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_rsp_data_next  = '0;
                    w_rsp_err_next   = 1'b1;
                    w_rsp_valid_next = r_owner;
                    w_state_next     = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
`endif
                end
            end
            ST_RESP: begin
                w_ptr_next   = (w_owner_idx == PW'(N_REQ - 1)) ? '0 : w_owner_idx + PW'(1);
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_busy_next = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_u_in      <= '0;
            r_u_start   <= 1'b0;
            r_busy      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt       <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_ptr       <= w_ptr_next;
            r_owner     <= w_owner_next;
            r_gnt       <= w_gnt_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_data  <= w_rsp_data_next;
            r_u_in      <= w_u_in_next;
            r_u_start   <= w_u_start_next;
            r_busy      <= w_busy_next;
`ifdef ARB_TIMEOUT_EN
            r_cnt       <= w_cnt_next;
            r_rsp_err   <= w_rsp_err_next;
`endif
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign u_in      = r_u_in;
    assign u_start   = r_u_start;
    assign busy      = r_busy;
`ifdef ARB_TIMEOUT_EN
    assign rsp_err   = r_rsp_err;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
